wb_commit: RTL and testbench

//  Writeback stage directly downstream of the issue stage.
//  - Queues register-file write requests from issue: destination and source select (ALU or LSU).
//  - Pairs each request, in order, with the matching ALU result or LSU read response.
//  - Drives the register-file write port.
//  - Optionally exports a pending-destination scoreboard for hazard checks in issue.

---
 rtl/wb_commit.sv | 145 ++++++++++++++
 tb/tb_wb_commit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit.sv
// Writeback stage: in-order pending-write queue that pairs issue requests with ALU/LSU results.
// Optional pending-destination scoreboard on busy_o, enabled by defining WB_SCOREBOARD_EN.
module wb_commit #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_rf_w_i,
  input  logic [ADDR_W-1:0]        rf_waddr_i,
  input  logic                     rf_soursel_i,
  output logic                     req_rf_ready_o,
  input  logic                     alu_valid_i,
  input  logic [DATA_W-1:0]        alu_result_i,
  output logic                     alu_ready_o,
  input  logic                     lsu_rvalid_i,
  input  logic [DATA_W-1:0]        lsu_rdata_i,
  input  logic                     lsu_err_i,
  output logic                     rf_we_o,
  output logic [ADDR_W-1:0]        rf_waddr_o,
  output logic [DATA_W-1:0]        rf_wdata_o,
  output logic                     lsu_err_o,
  output logic                     proto_err_o,
  output logic [$clog2(DEPTH):0]   pending_cnt_o,
  output logic [31:0]              busy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_WAIT_ALU,
    S_WAIT_LSU
  } head_state_t;

  head_state_t       state, state_nxt;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic              src_q  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_inc, head_ptr_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              enq, deq, deq_alu, deq_lsu, head_src_nxt, we_nxt;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] wdata_sel;

  assign req_rf_ready_o = (count != CNT_FULL);
  assign enq            = req_rf_w_i && req_rf_ready_o;
  assign pending_cnt_o  = count;
  assign head_addr      = addr_q[rd_ptr];
  assign rd_ptr_inc     = rd_ptr + PTR_ONE;

  // Head state tracks the entry that will sit at the head after this edge,
  // including a request written this cycle when it becomes the only entry.
  always_comb begin
    deq_alu      = 1'b0;
    deq_lsu      = 1'b0;
    alu_ready_o  = 1'b0;
    state_nxt    = S_EMPTY;
    count_nxt    = count;
    head_ptr_nxt = rd_ptr;
    head_src_nxt = 1'b0;
    case (state)
      S_WAIT_ALU: begin
        deq_alu     = alu_valid_i;
        alu_ready_o = alu_valid_i;
      end
      S_WAIT_LSU: deq_lsu = lsu_rvalid_i;
      default: ;
    endcase
    deq = deq_alu || deq_lsu;
    if (enq && !deq)      count_nxt = count + CNT_ONE;
    else if (!enq && deq) count_nxt = count - CNT_ONE;
    if (deq) head_ptr_nxt = rd_ptr_inc;
    if (enq && (head_ptr_nxt == wr_ptr)) head_src_nxt = rf_soursel_i;
    else                                 head_src_nxt = src_q[head_ptr_nxt];
    if (count_nxt != '0) state_nxt = head_src_nxt ? S_WAIT_LSU : S_WAIT_ALU;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_EMPTY;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        src_q[i]  <= 1'b0;
      end
    end else begin
      if (enq) begin
        addr_q[wr_ptr] <= rf_waddr_i;
        src_q[wr_ptr]  <= rf_soursel_i;
        wr_ptr         <= wr_ptr + PTR_ONE;
      end
      if (deq) rd_ptr <= rd_ptr_inc;
      count <= count_nxt;
    end
  end

  assign wdata_sel = deq_lsu ? lsu_rdata_i : alu_result_i;
  assign we_nxt    = deq && (head_addr != '0) && !(deq_lsu && lsu_err_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o     <= 1'b0;
      rf_waddr_o  <= '0;
      rf_wdata_o  <= '0;
      lsu_err_o   <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      rf_we_o   <= we_nxt;
      lsu_err_o <= deq_lsu && lsu_err_i;
      if (we_nxt) begin
        rf_waddr_o <= head_addr;
        rf_wdata_o <= wdata_sel;
      end
      if (lsu_rvalid_i && (state != S_WAIT_LSU)) proto_err_o <= 1'b1;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy;

  always_comb begin
    busy = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count) busy[addr_q[rd_ptr + PTR_W'(k)]] = 1'b1;
    end
    busy[0] = 1'b0;
  end

  assign busy_o = busy;
`else
  assign busy_o = '0;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Directed self-checking bench for wb_commit (DEPTH=2); busy_o expectations follow WB_SCOREBOARD_EN.
module tb_wb_commit;

`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [4:0]  waddr_in = '0;
  logic        src = 1'b0;
  logic        req_ready;
  logic        alu_valid = 1'b0;
  logic [31:0] alu_result = '0;
  logic        alu_ready;
  logic        lsu_rvalid = 1'b0;
  logic [31:0] lsu_rdata = '0;
  logic        lsu_err_in = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        lsu_err;
  logic        proto_err;
  logic [1:0]  pending;
  logic [31:0] busy;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  wb_commit #(.DEPTH(2), .ADDR_W(5), .DATA_W(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_rf_w_i    (req),
    .rf_waddr_i    (waddr_in),
    .rf_soursel_i  (src),
    .req_rf_ready_o(req_ready),
    .alu_valid_i   (alu_valid),
    .alu_result_i  (alu_result),
    .alu_ready_o   (alu_ready),
    .lsu_rvalid_i  (lsu_rvalid),
    .lsu_rdata_i   (lsu_rdata),
    .lsu_err_i     (lsu_err_in),
    .rf_we_o       (rf_we),
    .rf_waddr_o    (rf_waddr),
    .rf_wdata_o    (rf_wdata),
    .lsu_err_o     (lsu_err),
    .proto_err_o   (proto_err),
    .pending_cnt_o (pending),
    .busy_o        (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sb(input logic [31:0] v);
    return SB ? v : 32'h0;
  endfunction

  initial begin
    // reset state
    tick();
    tick();
    check_eq("rst_we", {31'b0, rf_we}, 32'd0);
    check_eq("rst_waddr", {27'b0, rf_waddr}, 32'd0);
    check_eq("rst_wdata", rf_wdata, 32'd0);
    check_eq("rst_lsu_err", {31'b0, lsu_err}, 32'd0);
    check_eq("rst_proto", {31'b0, proto_err}, 32'd0);
    check_eq("rst_pending", {30'b0, pending}, 32'd0);
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_ready", {31'b0, req_ready}, 32'd1);
    rst_n = 1'b1;

    // fill queue, then reset mid-queue
    req = 1'b1; waddr_in = 5'd9; src = 1'b0;
    tick();
    waddr_in = 5'd10;
    tick();
    req = 1'b0;
    check_eq("fill_pending", {30'b0, pending}, 32'd2);
    check_eq("fill_ready", {31'b0, req_ready}, 32'd0);
    check_eq("fill_busy", busy, sb(32'h600));
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_pending", {30'b0, pending}, 32'd0);
    check_eq("midrst_busy", busy, 32'd0);
    tick();
    rst_n = 1'b1;
    alu_valid = 1'b1; alu_result = 32'h1111_1111;
    #1 check_eq("postrst_alu_ready", {31'b0, alu_ready}, 32'd0);
    tick();
    check_eq("postrst_we", {31'b0, rf_we}, 32'd0);
    check_eq("postrst_pending", {30'b0, pending}, 32'd0);
    alu_valid = 1'b0;

    // ALU write to x5
    req = 1'b1; waddr_in = 5'd5; src = 1'b0;
    tick();
    req = 1'b0;
    check_eq("alu_pending", {30'b0, pending}, 32'd1);
    check_eq("alu_busy", busy, sb(32'h20));
    alu_valid = 1'b1; alu_result = 32'hDEAD_BEEF;
    #1 check_eq("alu_ready", {31'b0, alu_ready}, 32'd1);
    tick();
    check_eq("alu_we", {31'b0, rf_we}, 32'd1);
    check_eq("alu_waddr", {27'b0, rf_waddr}, 32'd5);
    check_eq("alu_wdata", rf_wdata, 32'hDEAD_BEEF);
    check_eq("alu_busy_clr", busy, 32'd0);
    alu_valid = 1'b0;
    tick();
    check_eq("alu_we_off", {31'b0, rf_we}, 32'd0);
    check_eq("alu_wdata_hold", rf_wdata, 32'hDEAD_BEEF);

    // ordering x3/LSU then x4/ALU, full, held third request x6
    req = 1'b1; waddr_in = 5'd3; src = 1'b1;
    tick();
    waddr_in = 5'd4; src = 1'b0;
    tick();
    check_eq("full_pending", {30'b0, pending}, 32'd2);
    check_eq("full_ready", {31'b0, req_ready}, 32'd0);
    check_eq("full_busy", busy, sb(32'h18));
    waddr_in = 5'd6; src = 1'b0;
    alu_valid = 1'b1; alu_result = 32'h4444_4444;
    #1 check_eq("ord_alu_held", {31'b0, alu_ready}, 32'd0);
    tick();
    check_eq("ord_no_we", {31'b0, rf_we}, 32'd0);
    check_eq("ord_pending_hold", {30'b0, pending}, 32'd2);
    lsu_rvalid = 1'b1; lsu_rdata = 32'h3333_3333;
    #1;
    check_eq("ord_ready_full_deq", {31'b0, req_ready}, 32'd0);
    check_eq("ord_alu_held2", {31'b0, alu_ready}, 32'd0);
    tick();
    check_eq("ord_x3_we", {31'b0, rf_we}, 32'd1);
    check_eq("ord_x3_addr", {27'b0, rf_waddr}, 32'd3);
    check_eq("ord_x3_data", rf_wdata, 32'h3333_3333);
    check_eq("ord_pending1", {30'b0, pending}, 32'd1);
    lsu_rvalid = 1'b0;
    #1 check_eq("ord_alu_ready", {31'b0, alu_ready}, 32'd1);
    tick();
    check_eq("ord_x4_we", {31'b0, rf_we}, 32'd1);
    check_eq("ord_x4_addr", {27'b0, rf_waddr}, 32'd4);
    check_eq("ord_x4_data", rf_wdata, 32'h4444_4444);
    check_eq("ord_simul_pending", {30'b0, pending}, 32'd1);
    req = 1'b0; alu_result = 32'h6666_6666;
    tick();
    check_eq("ord_x6_addr", {27'b0, rf_waddr}, 32'd6);
    check_eq("ord_x6_data", rf_wdata, 32'h6666_6666);
    check_eq("ord_empty", {30'b0, pending}, 32'd0);
    alu_valid = 1'b0;
    tick();

    // LSU error response on x8
    req = 1'b1; waddr_in = 5'd8; src = 1'b1;
    tick();
    req = 1'b0;
    lsu_rvalid = 1'b1; lsu_err_in = 1'b1; lsu_rdata = 32'hBAD0_BAD0;
    tick();
    lsu_rvalid = 1'b0; lsu_err_in = 1'b0;
    check_eq("err_we", {31'b0, rf_we}, 32'd0);
    check_eq("err_pulse", {31'b0, lsu_err}, 32'd1);
    check_eq("err_addr_hold", {27'b0, rf_waddr}, 32'd6);
    check_eq("err_pending", {30'b0, pending}, 32'd0);
    check_eq("err_no_proto", {31'b0, proto_err}, 32'd0);
    tick();
    check_eq("err_pulse_end", {31'b0, lsu_err}, 32'd0);

    // stray LSU response while empty
    lsu_rvalid = 1'b1;
    tick();
    lsu_rvalid = 1'b0;
    check_eq("proto_set", {31'b0, proto_err}, 32'd1);
    check_eq("proto_no_we", {31'b0, rf_we}, 32'd0);
    tick();
    check_eq("proto_sticky", {31'b0, proto_err}, 32'd1);

    // x0 destination: consumed, never written
    req = 1'b1; waddr_in = 5'd0; src = 1'b0;
    tick();
    req = 1'b0;
    check_eq("x0_pending", {30'b0, pending}, 32'd1);
    check_eq("x0_busy", busy, 32'd0);
    alu_valid = 1'b1; alu_result = 32'h1234_5678;
    #1 check_eq("x0_alu_ready", {31'b0, alu_ready}, 32'd1);
    tick();
    alu_valid = 1'b0;
    check_eq("x0_we", {31'b0, rf_we}, 32'd0);
    check_eq("x0_dequeued", {30'b0, pending}, 32'd0);
    check_eq("x0_wdata_hold", rf_wdata, 32'h6666_6666);

    // scoreboard on x7
    req = 1'b1; waddr_in = 5'd7; src = 1'b0;
    tick();
    req = 1'b0;
    check_eq("sb_x7_busy", busy, sb(32'h80));
    alu_valid = 1'b1; alu_result = 32'h0000_0077;
    tick();
    alu_valid = 1'b0;
    check_eq("sb_x7_we", {31'b0, rf_we}, 32'd1);
    check_eq("sb_x7_addr", {27'b0, rf_waddr}, 32'd7);
    check_eq("sb_x7_clr", busy, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
